// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the data-memory responder
// Contents:
//   dmem_state_t     responder FSM state encoding (IDLE / WAIT / RESP)
//   DMEM_LATENCY     default number of wait cycles per access
//   WORD_ALIGN_MASK  byte-address bits that must be zero for a word access
//   is_word_aligned  helper testing a byte address against WORD_ALIGN_MASK
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam int          DMEM_LATENCY    = 2;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_word_aligned(input logic [31:0] byte_addr);
        return (byte_addr & WORD_ALIGN_MASK) == 32'h0;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage load/store bus between pipeline and responder
// Signals:
//   memreadMEM   pipeline -> responder  load request
//   memwriteMEM  pipeline -> responder  store request
//   addr[31:0]   pipeline -> responder  byte address
//   wdata        pipeline -> responder  store data
//   rdata        responder -> pipeline  load data (holds last loaded word)
//   rdata_valid  responder -> pipeline  one-cycle load-complete pulse
//   memStall     responder -> pipeline  freeze upstream pipeline registers
//   err          responder -> pipeline  one-cycle pulse for a rejected request
// Modports: master = pipeline side, slave = responder side.
interface dmem_responder_if #(
    parameter int DATA_W = 32
) ();
    logic              memreadMEM;
    logic              memwriteMEM;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              memStall;
    logic              err;

    modport master (
        output memreadMEM, memwriteMEM, addr, wdata,
        input  rdata, rdata_valid, memStall, err
    );

    modport slave (
        input  memreadMEM, memwriteMEM, addr, wdata,
        output rdata, rdata_valid, memStall, err
    );
endinterface

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - single-port synchronous RAM with registered read
// Ports:
//   clk, rst_n  clock and async active-low reset (read register only)
//   i_en        access enable for this edge
//   i_we        1 = write i_wdata, 0 = load word into o_rdata
//   i_addr      word index
//   i_wdata     write data
//   o_rdata     registered read data; holds until the next read
// Array contents are deliberately not reset.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for the MEM stage
// Ports:
//   clk, rst_n     pipeline clock, async active-low reset
//   bus (slave)    load/store request, rdata/rdata_valid, memStall, err
//   stall_cycles   [DMEM_STATS_EN only] saturating count of stalled edges
//   access_count   [DMEM_STATS_EN only] wrapping count of completed accesses
// Optional feature macro: DMEM_STATS_EN.
// An accepted request stalls the pipeline for LATENCY+1 cycles, touches the
// array on the last WAIT edge, then spends one RESP cycle unstalled while the
// pipeline advances past the (now stale) request.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       access_count
`endif
);
    dmem_state_t       r_state;
    logic [3:0]        r_cnt;
    logic              r_is_load;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rvalid;

    logic              w_req;
    logic              w_illegal;
    logic              w_accept;
    logic              w_reject;
    logic              w_mem_en;
    logic              w_stall;
    logic [DATA_W-1:0] w_arr_rdata;

    assign w_req     = bus.memreadMEM | bus.memwriteMEM;
    assign w_illegal = !is_word_aligned(bus.addr) | (bus.memreadMEM & bus.memwriteMEM);

    // Qualified with rst_n so a request left asserted during reset cannot
    // hold memStall/err high while the FSM is forced to IDLE.
    assign w_accept  = rst_n & (r_state == ST_IDLE) & w_req & !w_illegal;
    assign w_reject  = rst_n & (r_state == ST_IDLE) & w_req &  w_illegal;

    assign w_mem_en  = (r_state == ST_WAIT) && (r_cnt == 4'd0);

    // Stall must rise in the accept cycle itself so the pipeline holds the
    // request steady; afterwards it is purely a decode of WAIT.
    assign w_stall   = w_accept | (r_state == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_is_load <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rvalid <= 1'b0;
                    if (w_accept) begin
                        r_is_load <= bus.memreadMEM;
                        r_idx     <= bus.addr[ADDR_W+1:2];
                        r_wdata   <= bus.wdata;
                        r_cnt     <= 4'(LATENCY - 1);
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rvalid <= r_is_load;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Inputs still show the completed request; do not re-accept.
                    r_rvalid <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_rvalid <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_mem_en),
        .i_we    (!r_is_load),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign bus.rdata       = w_arr_rdata;
    assign bus.rdata_valid = r_rvalid;
    assign bus.memStall    = w_stall;
    assign bus.err         = w_reject;

`ifdef DMEM_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_access_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 32'd0;
            r_access_count <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (r_state == ST_RESP) begin
                r_access_count <= r_access_count + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign access_count = r_access_count;
`endif
endmodule
